spi_config_commit: RTL

- Single-clock consumer of the SPI configuration interface outputs.
- Brings the SPI-domain signals into the core clock domain: spi_instruction_done, SS, clk_div_ready, debug_config_ready and the 125-byte all_data_out bus.
- After each completed SPI instruction, waits until SS is released and the bus has been stable for a programmable settle time.
- Then commits the bus into a shadow register that the SNN core uses, and pulses an update strobe.

---
 rtl/spi_config_commit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/spi_config_commit.sv
// Commits the SPI configuration bus into a core-domain shadow register
// once an instruction has completed and SS has been released long enough.
module spi_config_commit #(
    parameter int DATA_W        = 1000,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_done_async,
    input  logic              ss_async,
    input  logic              clk_div_ready_async,
    input  logic              debug_cfg_ready_async,
    input  logic [DATA_W-1:0] cfg_bus_in,
    output logic [DATA_W-1:0] shadow_out,
    output logic              cfg_update,
    output logic              cfg_valid,
    output logic              clk_div_en,
    output logic              debug_cfg_en,
    output logic              busy,
    output logic [CNT_W-1:0]  commit_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_SS = 2'd1;
    localparam logic [1:0] SETTLE  = 2'd2;
    localparam logic [1:0] CAPTURE = 2'd3;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] LAST = SW'(SETTLE_CYCLES - 1);

    logic done_s1_q, done_s2_q, done_d_q;
    logic ss_s1_q, ss_s2_q;
    logic cdr_s1_q, cdr_s2_q;
    logic dbg_s1_q, dbg_s2_q;

    logic [1:0]        state_q, state_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              update_q, update_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic done_rise;

    assign done_rise = done_s2_q & ~done_d_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        shadow_d  = shadow_q;
        update_d  = 1'b0;
        valid_d   = valid_q;
        count_d   = count_q;
        unique case (state_q)
            IDLE: begin
                if (done_rise || pending_q) begin
                    state_d   = WAIT_SS;
                    pending_d = 1'b0;
                end
            end
            WAIT_SS: begin
                if (ss_s2_q) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!ss_s2_q) begin
                    state_d = WAIT_SS;
                end else if (cnt_q == LAST) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                shadow_d = cfg_bus_in;
                update_d = 1'b1;
                valid_d  = 1'b1;
                count_d  = count_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // An edge that IDLE is not consuming on its own is remembered
        if (done_rise && (state_q != IDLE || pending_q)) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_s1_q <= 1'b0;
            done_s2_q <= 1'b0;
            done_d_q  <= 1'b0;
            ss_s1_q   <= 1'b1;
            ss_s2_q   <= 1'b1;
            cdr_s1_q  <= 1'b0;
            cdr_s2_q  <= 1'b0;
            dbg_s1_q  <= 1'b0;
            dbg_s2_q  <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            shadow_q  <= '0;
            update_q  <= 1'b0;
            valid_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            done_s1_q <= spi_done_async;
            done_s2_q <= done_s1_q;
            done_d_q  <= done_s2_q;
            ss_s1_q   <= ss_async;
            ss_s2_q   <= ss_s1_q;
            cdr_s1_q  <= clk_div_ready_async;
            cdr_s2_q  <= cdr_s1_q;
            dbg_s1_q  <= debug_cfg_ready_async;
            dbg_s2_q  <= dbg_s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            update_q  <= update_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
        end
    end

    assign shadow_out   = shadow_q;
    assign cfg_update   = update_q;
    assign cfg_valid    = valid_q;
    assign commit_count = count_q;
    assign busy         = (state_q != IDLE);
    assign clk_div_en   = cdr_s2_q & valid_q;
    assign debug_cfg_en = dbg_s2_q & valid_q;

endmodule
